// File: rtl/dm_store_buffer_pkg.sv
// Shared definitions for the MEM-stage store buffer: store op codes and
// the byte-enable patterns used by the lane generator.
package dm_store_buffer_pkg;

    // Store op codes as presented by the MEM stage
    typedef enum logic [1:0] {
        ST_SW  = 2'd0,
        ST_SH  = 2'd1,
        ST_SB  = 2'd2,
        ST_RSV = 2'd3
    } storeOpT;

    // Byte-enable patterns (bit i = byte lane i)
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;

endpackage

// File: rtl/dm_store_buffer_if.sv
// Bus bundle between the MEM stage (master) and the store buffer (slave),
// including the data-memory write port driven by the buffer.
//
// Handshake: a store transfers on a rising edge when st_valid=1 and
// st_stall=0 (st_stall is the inverse of ready). The master must hold
// st_valid/st_op/st_addr/st_data stable while st_stall=1. st_stall only
// asserts for legal stores; illegal ones are dropped and reported through
// align_err on the next cycle. dm_we has no back-pressure: the memory takes
// the write in the cycle it is presented.
interface dm_store_buffer_if #(
    parameter int ADDR_W = 10
);
    logic              st_valid;
    logic [1:0]        st_op;
    logic [31:0]       st_addr;
    logic [31:0]       st_data;
    logic              ld_valid;
    logic [31:0]       ld_addr;
    logic              dm_busy;
    logic              st_stall;
    logic              ld_hazard;
    logic              align_err;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] dm_waddr;
    logic [31:0]       dm_wdata;
    logic              empty;

    modport master (
        output st_valid, st_op, st_addr, st_data, ld_valid, ld_addr, dm_busy,
        input  st_stall, ld_hazard, align_err, dm_we, dm_be, dm_waddr, dm_wdata, empty
    );

    modport slave (
        input  st_valid, st_op, st_addr, st_data, ld_valid, ld_addr, dm_busy,
        output st_stall, ld_hazard, align_err, dm_we, dm_be, dm_waddr, dm_wdata, empty
    );
endinterface

// File: rtl/dm_store_buffer_store_lane_gen.sv
// Turns a store op plus the low address bits into byte enables and
// lane-replicated write data, and flags misaligned or reserved requests.
module store_lane_gen
    import dm_store_buffer_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  addrLo,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        legal
);

    // Decode op into lanes; replicate the narrow value across all lanes so
    // the memory only needs byte enables to pick the right one.
    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0;
        legal = 1'b0;
        case (op)
            ST_SW: begin
                legal = (addrLo == 2'b00);
                be    = BE_WORD;
                wdata = data;
            end
            ST_SH: begin
                legal = ~addrLo[0];
                be    = addrLo[1] ? BE_HI : BE_LO;
                wdata = {2{data[15:0]}};
            end
            ST_SB: begin
                legal = 1'b1;
                be    = 4'b0001 << addrLo;
                wdata = {4{data[7:0]}};
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dm_store_buffer.sv
// MEM-stage store buffer: queues legal stores in a small FIFO, drains one
// entry per free data-memory cycle through a registered write port, and
// flags loads that touch a word still waiting to be written.
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    dm_store_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [ADDR_W-1:0] wordMem [DEPTH];
    logic [3:0]        beMem   [DEPTH];
    logic [31:0]       dataMem [DEPTH];

    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W:0]    count;

    logic [3:0]        laneBe;
    logic [31:0]       laneData;
    logic              laneLegal;
    logic              doEnq;
    logic              doDrain;
    logic              hazardHit;
    logic [PTR_W-1:0]  offset;

    logic [ADDR_W-1:0] stWord;
    logic [ADDR_W-1:0] ldWord;
    logic              unusedAddrBits;

    store_lane_gen laneGen (
        .op     (bus.st_op),
        .addrLo (bus.st_addr[1:0]),
        .data   (bus.st_data),
        .be     (laneBe),
        .wdata  (laneData),
        .legal  (laneLegal)
    );

    assign stWord = bus.st_addr[ADDR_W+1:2];
    assign ldWord = bus.ld_addr[ADDR_W+1:2];
    assign unusedAddrBits = ^{bus.st_addr[31:ADDR_W+2], bus.ld_addr[31:ADDR_W+2], bus.ld_addr[1:0]};

    // A drain in the same cycle never frees a slot for that cycle's store:
    // the full test looks only at the current count.
    assign doEnq        = bus.st_valid & laneLegal & (count != FULL_COUNT);
    assign bus.st_stall = bus.st_valid & laneLegal & (count == FULL_COUNT);
    assign doDrain      = (count != '0) & ~bus.dm_busy;
    assign bus.empty    = (count == '0) & ~bus.dm_we;

    // Compare the load word against every occupied slot and the write register
    always_comb begin
        hazardHit = bus.dm_we & (bus.dm_waddr == ldWord);
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rdPtr;
            if (({1'b0, offset} < count) && (wordMem[i] == ldWord)) begin
                hazardHit = 1'b1;
            end
        end
    end

    assign bus.ld_hazard = bus.ld_valid & hazardHit;

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                wordMem[i] <= '0;
                beMem[i]   <= '0;
                dataMem[i] <= '0;
            end
        end else begin
            if (doEnq) begin
                wordMem[wrPtr] <= stWord;
                beMem[wrPtr]   <= laneBe;
                dataMem[wrPtr] <= laneData;
                wrPtr          <= wrPtr + 1'b1;
            end
            if (doDrain) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doEnq, doDrain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered write port and one-cycle alignment error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.dm_we     <= 1'b0;
            bus.dm_be     <= '0;
            bus.dm_waddr  <= '0;
            bus.dm_wdata  <= '0;
            bus.align_err <= 1'b0;
        end else begin
            bus.align_err <= bus.st_valid & ~laneLegal;
            if (doDrain) begin
                bus.dm_we    <= 1'b1;
                bus.dm_be    <= beMem[rdPtr];
                bus.dm_waddr <= wordMem[rdPtr];
                bus.dm_wdata <= dataMem[rdPtr];
            end else begin
                bus.dm_we    <= 1'b0;
                bus.dm_be    <= '0;
                bus.dm_waddr <= '0;
                bus.dm_wdata <= '0;
            end
        end
    end

endmodule
